hilo_muldiv_unit: RTL and testbench



---
 rtl/hilo_muldiv_unit_if.sv | 27 ++
 rtl/hilo_muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// Bus between the execute stage and the HI/LO multiply/divide unit.
// The stage drives instruction/operand signals; the unit returns HI/LO and stall control.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             mthi;
  logic             mtlo;
  logic             hilo_rd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             pc_en;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo, hilo_rd,
    input  hi, lo, busy, pc_en
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo, hilo_rd,
    output hi, lo, busy, pc_en
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: one shift-add or
// restoring-subtract step per cycle on unsigned magnitudes, sign fix-up at the end.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  hilo_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  state_t             state_q;
  logic [5:0]         cnt_q;
  logic               busy_q;
  logic               div_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic               dz_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               signed_op;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_d;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;

  // op[0] set means unsigned; op[1] set means divide.
  always_comb begin
    signed_op = ~bus.op[0];
    rs_neg    = signed_op & bus.rs_data[WIDTH-1];
    rt_neg    = signed_op & bus.rt_data[WIDTH-1];
    rs_mag    = rs_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
    rt_mag    = rt_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;
  end

  // prod_q holds {partial, multiplier} for multiply and {remainder, dividend} for divide.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opb_q : {WIDTH{1'b0}})};
    div_diff = {1'b0, prod_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opb_q};
    prod_d   = {mul_sum, prod_q[WIDTH-1:1]};
    if (div_q) begin
      if (!div_diff[WIDTH+1]) begin
        prod_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
      end else begin
        prod_d = {prod_q[2*WIDTH-2:0], 1'b0};
      end
    end
  end

  // A zero divisor yields an all-ones quotient and the dividend as remainder;
  // only the quotient sign correction must be suppressed for DIV.
  always_comb begin
    prod_neg = ~prod_q + 1'b1;
    quo      = prod_q[WIDTH-1:0];
    rem      = prod_q[2*WIDTH-1:WIDTH];
    hi_d     = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : rem;
    lo_d     = neg_q ? prod_neg[WIDTH-1:0] : quo;
    if (div_q) begin
      hi_d = rem_neg_q ? (~rem + 1'b1) : rem;
      if (dz_q) begin
        lo_d = {WIDTH{1'b1}};
      end else begin
        lo_d = neg_q ? (~quo + 1'b1) : quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      opb_q     <= '0;
      prod_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            div_q     <= bus.op[1];
            neg_q     <= rs_neg ^ rt_neg;
            rem_neg_q <= rs_neg;
            dz_q      <= (bus.rt_data == '0);
            opb_q     <= rt_mag;
            prod_q    <= {{WIDTH{1'b0}}, rs_mag};
          end else begin
            if (bus.mthi) hi_q <= bus.rs_data;
            if (bus.mtlo) lo_q <= bus.rs_data;
          end
        end
        S_RUN: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + 6'd1;
          if (cnt_q == CNT_LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.pc_en = ~(busy_q & (bus.start | bus.mthi | bus.mtlo | bus.hilo_rd));

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench: directed corner cases plus random ops against an arithmetic HI/LO model.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus();
  hilo_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // MIPS semantics straight from arithmetic: truncating division, remainder takes dividend sign.
  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    case (op)
      2'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'd1: begin u = {32'd0, a} * {32'd0, b}; h = u[63:32]; l = u[31:0]; end
      default: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFF_FFFF;
        end else if (op == 2'd2) begin
          p = sa / sb; l = p[31:0];
          p = sa % sb; h = p[31:0];
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic with_mt);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b; bus.mthi = with_mt;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.mthi = 1'b0;
    bus.op = 2'($urandom); bus.rs_data = $urandom; bus.rt_data = $urandom;
  endtask

  task automatic wait_done(output int busy_n, output int stall_n);
    busy_n = 0;
    stall_n = 0;
    while (bus.busy && busy_n < 200) begin
      busy_n++;
      if (!bus.pc_en) stall_n++;
      if (busy_n == 16) chk("hold_hi", {32'd0, bus.hi}, {32'd0, m_hi});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic with_mt);
    int n, s;
    start_op(op, a, b, with_mt);
    wait_done(n, s);
    chk({tag, "_lat"}, 64'(n), 64'd33);
    ref_op(op, a, b, m_hi, m_lo);
    chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, m_hi});
    chk({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, m_lo});
  endtask

  initial begin
    int n, s;
    logic [1:0] op;
    logic [31:0] a, b;

    bus.start = 0; bus.op = 0; bus.rs_data = 0; bus.rt_data = 0;
    bus.mthi = 0; bus.mtlo = 0; bus.hilo_rd = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("rst_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_pcen", {63'd0, bus.pc_en}, 64'd1);

    bus.hilo_rd = 1'b1;
    #1;
    chk("idle_rd_pcen", {63'd0, bus.pc_en}, 64'd1);
    bus.hilo_rd = 1'b0;

    do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("mult_m3x7", 2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    do_op("mult_min2", 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op("div_m7d2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op("divu_dz", 2'd3, 32'd100, 32'd0, 1'b0);
    do_op("div_dz", 2'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
    do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // MFLO held from the cycle after acceptance must stall for the whole operation.
    start_op(2'd1, 32'd6, 32'd7, 1'b0);
    bus.hilo_rd = 1'b1;
    wait_done(n, s);
    chk("stall_cnt", 64'(s), 64'd33);
    chk("stall_pcen", {63'd0, bus.pc_en}, 64'd1);
    chk("stall_lo", {32'd0, bus.lo}, 64'd42);
    bus.hilo_rd = 1'b0;
    ref_op(2'd1, 32'd6, 32'd7, m_hi, m_lo);

    // MTLO issued during busy waits, then lands after the result.
    a = $urandom; b = $urandom;
    start_op(2'd1, a, b, 1'b0);
    bus.mtlo = 1'b1; bus.rs_data = 32'd5;
    wait_done(n, s);
    ref_op(2'd1, a, b, m_hi, m_lo);
    chk("mtlo_stall", 64'(s), 64'd33);
    chk("mtlo_prelo", {32'd0, bus.lo}, {32'd0, m_lo});
    @(posedge clk);
    #1;
    bus.mtlo = 1'b0;
    m_lo = 32'd5;
    chk("mtlo_lo", {32'd0, bus.lo}, {32'd0, m_lo});
    chk("mtlo_hi", {32'd0, bus.hi}, {32'd0, m_hi});

    // Reset in the middle of a divide.
    @(negedge clk);
    bus.mthi = 1'b1; bus.rs_data = 32'h1234;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    m_hi = 32'h1234;
    chk("mthi_hi", {32'd0, bus.hi}, {32'd0, m_hi});
    start_op(2'd3, 32'd1000, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_hi", {32'd0, bus.hi}, 64'd0);
    chk("abort_lo", {32'd0, bus.lo}, 64'd0);
    chk("abort_pcen", {63'd0, bus.pc_en}, 64'd1);
    do_op("post_abort", 2'd1, 32'd2, 32'd3, 1'b0);

    // Random ops; an MTHI coinciding with start must lose to start.
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      do_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
